// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises one clipped filled rectangle or full-screen clear into per-cycle pixel writes
module rect_fill_engine #(
   parameter int X_WIDTH     = 9,
   parameter int Y_WIDTH     = 8,
   parameter int COLOR_WIDTH = 3,
   parameter int X_MAX       = 319,
   parameter int Y_MAX       = 239
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_clear,
   input  logic [X_WIDTH-1:0]     cmd_x,
   input  logic [Y_WIDTH-1:0]     cmd_y,
   input  logic [X_WIDTH-1:0]     cmd_w,
   input  logic [Y_WIDTH-1:0]     cmd_h,
   input  logic [COLOR_WIDTH-1:0] cmd_color,
   output logic [X_WIDTH-1:0]     x,
   output logic [Y_WIDTH-1:0]     y,
   output logic [COLOR_WIDTH-1:0] color,
   output logic                   wr_en,
   output logic                   busy,
   output logic                   done
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   localparam logic [X_WIDTH:0] XM = (X_WIDTH+1)'(X_MAX);
   localparam logic [Y_WIDTH:0] YM = (Y_WIDTH+1)'(Y_MAX);
   state_t state, state_n;
   logic [X_WIDTH-1:0] x0, x1, x_n, x0_n, x1_n, ax0, ax1;
   logic [Y_WIDTH-1:0] y1, y_n, y1_n, ay0, ay1;
   logic [COLOR_WIDTH-1:0] color_n;
   logic [X_WIDTH:0] xe;
   logic [Y_WIDTH:0] ye;
   logic wr_en_n, done_n, empty;
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   always_comb begin
      ax0   = cmd_clear ? '0 : cmd_x;
      ay0   = cmd_clear ? '0 : cmd_y;
      xe    = {1'b0, ax0} + {1'b0, cmd_w} - (X_WIDTH+1)'(1);
      ye    = {1'b0, ay0} + {1'b0, cmd_h} - (Y_WIDTH+1)'(1);
      ax1   = (cmd_clear || xe > XM) ? XM[X_WIDTH-1:0] : xe[X_WIDTH-1:0];
      ay1   = (cmd_clear || ye > YM) ? YM[Y_WIDTH-1:0] : ye[Y_WIDTH-1:0];
      empty = !cmd_clear && (cmd_w == '0 || cmd_h == '0 || {1'b0, cmd_x} > XM || {1'b0, cmd_y} > YM);
   end
   always_comb begin
      state_n = state;
      x_n     = x;
      y_n     = y;
      color_n = color;
      wr_en_n = wr_en;
      done_n  = 1'b0;
      x0_n    = x0;
      x1_n    = x1;
      y1_n    = y1;
      case (state)
         IDLE: if (cmd_valid) begin
            if (empty) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               state_n = DRAW;
               x_n     = ax0;
               y_n     = ay0;
               color_n = cmd_color;
               wr_en_n = 1'b1;
               x0_n    = ax0;
               x1_n    = ax1;
               y1_n    = ay1;
            end
         end
         DRAW: if (x == x1 && y == y1) begin
            state_n = DONE;
            wr_en_n = 1'b0;
            done_n  = 1'b1;
         end else begin
            x_n = (x == x1) ? x0 : x + X_WIDTH'(1);
            y_n = (x == x1) ? y + Y_WIDTH'(1) : y;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         color <= '0;
         wr_en <= 1'b0;
         done  <= 1'b0;
         x0    <= '0;
         x1    <= '0;
         y1    <= '0;
      end else begin
         state <= state_n;
         x     <= x_n;
         y     <= y_n;
         color <= color_n;
         wr_en <= wr_en_n;
         done  <= done_n;
         x0    <= x0_n;
         x1    <= x1_n;
         y1    <= y1_n;
      end
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed commands with a pixel scoreboard checked by an independent write monitor
module tb_rect_fill_engine;
   logic clk = 0, reset = 0, cmd_valid = 0, cmd_clear = 0;
   logic [8:0] cmd_x = 0, cmd_w = 0;
   logic [7:0] cmd_y = 0, cmd_h = 0;
   logic [2:0] cmd_color = 0;
   logic cmd_ready, wr_en, busy, done;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] color;
   int checks = 0, fails = 0, done_cnt = 0;
   logic [19:0] exp_q[$];
   int hit[320][240];
   bit track = 0;

   always #5 clk = ~clk;

   rect_fill_engine dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_color(cmd_color), .x(x), .y(y), .color(color), .wr_en(wr_en), .busy(busy), .done(done)
   );

   always @(negedge clk) begin
      if (reset && done) done_cnt++;
      if (reset && wr_en) begin
         logic [19:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write got x=%0d y=%0d c=%0d, none expected", x, y, color);
         end else begin
            e = exp_q.pop_front();
            if ({x, y, color} !== e) begin
               fails++;
               $display("FAIL pixel got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                        x, y, color, e[19:11], e[10:3], e[2:0]);
            end
         end
         if (track && x < 320 && y < 240) hit[x][y]++;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic push_rect(input int x0, input int y0, input int w, input int h, input int c);
      int xe, ye;
      if (w == 0 || h == 0 || x0 > 319 || y0 > 239) return;
      xe = (x0 + w - 1 > 319) ? 319 : x0 + w - 1;
      ye = (y0 + h - 1 > 239) ? 239 : y0 + h - 1;
      for (int yy = y0; yy <= ye; yy++)
         for (int xx = x0; xx <= xe; xx++)
            exp_q.push_back({9'(xx), 8'(yy), 3'(c)});
   endtask

   task automatic issue(input bit clr, input int xx, input int yy, input int ww, input int hh,
                        input int cc, input bit hold);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_issue", cmd_ready, 1);
      cmd_clear = clr;
      cmd_x = 9'(xx);
      cmd_y = 8'(yy);
      cmd_w = 9'(ww);
      cmd_h = 8'(hh);
      cmd_color = 3'(cc);
      cmd_valid = 1;
      if (clr) push_rect(0, 0, 320, 240, cc);
      else push_rect(xx, yy, ww, hh, cc);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 0;
   endtask

   task automatic wait_done(input string name, input int exp_n);
      int n = 0;
      forever begin
         @(negedge clk);
         if (done || n > 80000) break;
         n++;
      end
      chk(name, n, exp_n);
      chk({name, "_queue"}, exp_q.size(), 0);
   endtask

   initial begin
      int ex[4][4] = '{'{10, 20, 0, 2}, '{10, 20, 2, 0}, '{400, 20, 1, 1}, '{10, 250, 1, 1}};
      int pat[10] = '{2, 2, 2, 1, 0, 2, 2, 2, 1, 0};
      int bad, dc, n;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xyc", {x, y, color}, 0);
      reset = 1;
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);

      issue(0, 10, 20, 2, 2, 5, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("r2x2_wr_%0d", i), wr_en, i < 4);
         chk($sformatf("r2x2_done_%0d", i), done, i == 4);
         chk($sformatf("r2x2_ready_%0d", i), cmd_ready, i == 5);
      end
      chk("r2x2_queue", exp_q.size(), 0);

      issue(0, 318, 239, 5, 3, 2, 0);
      wait_done("clip_done", 2);

      for (int k = 0; k < 4; k++) begin
         issue(0, ex[k][0], ex[k][1], ex[k][2], ex[k][3], 6, 0);
         @(negedge clk);
         chk($sformatf("empty%0d_done", k), done, 1);
         chk($sformatf("empty%0d_busy", k), busy, 1);
         chk($sformatf("empty%0d_wr", k), wr_en, 0);
         @(negedge clk);
         chk($sformatf("empty%0d_busy_off", k), busy, 0);
         chk($sformatf("empty%0d_done_off", k), done, 0);
      end

      foreach (hit[i, j]) hit[i][j] = 0;
      track = 1;
      issue(1, 77, 33, 5, 5, 0, 0);
      wait_done("clear_done", 76800);
      track = 0;
      bad = 0;
      foreach (hit[i, j]) if (hit[i][j] != 1) bad++;
      chk("clear_coverage_bad_cells", bad, 0);

      issue(0, 20, 30, 50, 50, 4, 0);
      while (exp_q.size() > 37) void'(exp_q.pop_back());
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("abort_37_writes", exp_q.size(), 0);
      dc = done_cnt;
      reset = 0;
      #1;
      chk("abort_wr_en_async", wr_en, 0);
      chk("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);
      chk("abort_ready", cmd_ready, 1);
      issue(0, 5, 5, 1, 1, 7, 0);
      wait_done("after_abort_1x1", 1);

      issue(0, 100, 50, 1, 3, 3, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("b2b_wr_done_%0d", i), {wr_en, done}, pat[i]);
         if (i == 4) chk("b2b_idle_ready", cmd_ready, 1);
         if (i == 0) begin
            cmd_x = 200;
            cmd_y = 60;
            cmd_color = 6;
            push_rect(200, 60, 1, 3, 6);
         end
         if (i == 5) cmd_valid = 0;
      end
      chk("b2b_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Upstream drawing stage for the 320x240, 3-bit-colour bitmap frame buffer. It accepts one filled-rectangle command at a time, or one full-screen clear, through a valid/ready handshake. It emits one pixel write per clock on the frame buffer's x/y/color/wr_en write port. Game logic (paddles, ball, score) drives it in the user clock domain.

Parameters:
X_WIDTH, 9, width of the x coordinate and of the width field
Y_WIDTH, 8, width of the y coordinate and of the height field
COLOR_WIDTH, 3, colour width (R,G,B one bit each)
X_MAX, 319, last visible column
Y_MAX, 239, last visible row

Ports:
clk  input  1  user clock; all logic on the rising edge
reset  input  1  asynchronous active-low reset; asserted when 0
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command; combinational, high only in IDLE
cmd_clear  input  1  1 = clear the full screen; cmd_x/y/w/h are ignored
cmd_x  input  X_WIDTH  left column
cmd_y  input  Y_WIDTH  top row
cmd_w  input  X_WIDTH  width in pixels
cmd_h  input  Y_WIDTH  height in pixels
cmd_color  input  COLOR_WIDTH  fill colour
x  output  X_WIDTH  write column (registered)
y  output  Y_WIDTH  write row (registered)
color  output  COLOR_WIDTH  write colour (registered)
wr_en  output  1  pixel write strobe (registered)
busy  output  1  high in DRAW or DONE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; x, y, color, wr_en, done = 0; busy = 0; cmd_ready = 1 once reset is released. A reset during DRAW aborts the command immediately: wr_en falls without waiting for a clock edge, and no further writes or done pulse follow.
- States:
  - IDLE: cmd_ready=1.
  - DRAW: one write per cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accept: a rising edge with cmd_valid=1 in IDLE latches the command. A clear becomes x0=0, y0=0, x1=X_MAX, y1=Y_MAX.
- Clipping, computed with one extra bit so arithmetic never overflows:
  - x1 = min(x0+w-1, X_MAX); y1 = min(y0+h-1, Y_MAX).
  - The command is empty if w=0, h=0, x0>X_MAX or y0>Y_MAX.
- Non-empty command, on the accepting edge:
  - x<=x0, y<=y0, color<=cmd_color, wr_en<=1; state DRAW.
  - The first write is visible in the cycle after acceptance (latency 1).
- Empty command, on the accepting edge: state DONE, done<=1, no write at all.
- DRAW raster order: x increments fastest.
  - When x==x1: x<=x0 and y<=y+1.
  - On the edge after the write of (x1,y1): wr_en<=0, done<=1, state DONE.
  - Total writes = (x1-x0+1)*(y1-y0+1), one per consecutive cycle with no gaps.
- DONE: on the next edge done<=0, state IDLE. cmd_ready rises in that cycle, so the minimum command-to-command gap equals the write count + 2 cycles.
- Held outputs: while wr_en=0, x/y/color keep their last values; downstream ignores them.
- Back-pressure: cmd_valid may stay high across commands; fields are sampled only on accept. Changes to cmd_* while busy are ignored.
- Write port: never stalls. The frame-buffer write port accepts every cycle, so there is no backpressure on wr_en.

Test Plan:
- 2x2 rect, x=10, y=20, color=5, accepted at edge E0 -> wr_en high for 4 cycles after E0, writing (10,20), (11,20), (10,21), (11,21), all colour 5. done pulses after E4; cmd_ready returns after E5.
- Clip: x=318, y=239, w=5, h=3, color=2 -> exactly 2 writes, (318,239) and (319,239), then done. No write has x>319 or y>239.
- Empty commands: w=0; h=0; x=400; y=250 -> zero wr_en cycles. done pulses on the cycle after accept; busy is high for exactly 1 cycle.
- Clear, color=0 -> exactly 76800 consecutive writes covering every (x,y) once, starting at (0,0) and ending at (319,239), then done. The scoreboard compares against a 320x240 model.
- Reset mid-draw: 50x50 rect, reset=0 after 37 writes -> wr_en=0 immediately (asynchronous), done never pulses. After release cmd_ready=1, and a new 1x1 at (5,5) writes exactly (5,5).
- Back-to-back: cmd_valid held high with two queued 1x3 commands -> 3 writes, done, one IDLE cycle, then 3 writes of the second command. The second command's fields are sampled only at its accept edge.
